// File: rtl/imem_loader.sv
// Boot loader: assembles 20-bit instruction words from a byte stream, writes them from address 0, then releases the core.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 512,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [19:0]   wd,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK = 3'd6
`endif
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    cnt_lo_q, cnt_lo_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [19:0]   wd_q, wd_d;
  logic [15:0]   n_hdr;
  logic          accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  // Handshake: a byte transfers on a clock edge where byte_valid and byte_ready are both high;
  // byte_valid while byte_ready is low is dropped, never buffered.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_IDLE) || (state_q == S_HDR_HI) ||
                      (state_q == S_DATA) || (state_q == S_CHECK);
`else
  assign byte_ready = (state_q == S_IDLE) || (state_q == S_HDR_HI) || (state_q == S_DATA);
`endif
  assign accept = byte_valid && byte_ready;
  assign n_hdr  = {byte_data, cnt_lo_q};

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (accept && (state_q != S_CHECK)) csum_d = csum_q ^ byte_data;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_lo_d = byte_data;
        state_d  = S_HDR_HI;
      end
      S_HDR_HI: if (accept) begin
        n_d        = n_hdr;
        word_idx_d = 16'd0;
        byte_idx_d = 2'd0;
        if (n_hdr > DEPTH16)     state_d = S_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else if (n_hdr == 16'd0) state_d = S_CHECK;
`else
        else if (n_hdr == 16'd0) state_d = S_FINISH;
`endif
        else                     state_d = S_DATA;
      end
      S_DATA: if (accept) begin
        case (byte_idx_q)
          2'd0: begin b0_d = byte_data; byte_idx_d = 2'd1; end
          2'd1: begin b1_d = byte_data; byte_idx_d = 2'd2; end
          default: begin
            we_d       = 1'b1;
            wa_d       = word_idx_q[AW-1:0];
            wd_d       = {byte_data[3:0], b1_q, b0_q};
            byte_idx_d = 2'd0;
            if (word_idx_q + 16'd1 == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_FINISH;
`endif
            end else begin
              word_idx_d = word_idx_q + 16'd1;
            end
          end
        endcase
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Verdict goes straight to DONE/ERROR so it is visible the cycle after the checksum byte.
      S_CHECK: if (accept) state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
`endif
      S_FINISH: state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_lo_q   <= 8'd0;
      n_q        <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      b0_q       <= 8'd0;
      b1_q       <= 8'd0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= 20'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign we         = we_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign core_reset = (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);

endmodule
